demux31_reg: RTL and testbench

DEMUX31_REG -- requirements
Module: demux31_reg

---
 rtl/demux31_reg_if.sv | 29 ++
 rtl/demux31_reg.sv | 98 +++++++++
 tb/tb_demux31_reg.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/demux31_reg_if.sv
// Bus bundle for demux31_reg: one producer input port and three consumer channels.
interface demux31_reg_if;
  logic [31:0] in_data;
  logic [1:0]  in_sel;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a_data;
  logic        a_valid;
  logic        a_ready;
  logic [31:0] b_data;
  logic        b_valid;
  logic        b_ready;
  logic [31:0] c_data;
  logic        c_valid;
  logic        c_ready;
  logic [7:0]  drop_cnt;

  // Producer/consumer side (testbench or surrounding logic)
  modport master (
    output in_data, in_sel, in_valid, a_ready, b_ready, c_ready,
    input  in_ready, a_data, a_valid, b_data, b_valid, c_data, c_valid, drop_cnt
  );

  // Demux side
  modport slave (
    input  in_data, in_sel, in_valid, a_ready, b_ready, c_ready,
    output in_ready, a_data, a_valid, b_data, b_valid, c_data, c_valid, drop_cnt
  );
endinterface

// File: rtl/demux31_reg.sv
// demux31_reg: routes a valid/ready input word to one of three single-entry
// registered output channels (a/b/c) or drops it (sel=11).
// Optional feature: define DEMUX31_DROP_CNT_EN to get a saturating 8-bit
// count of dropped words on drop_cnt; otherwise drop_cnt is tied to zero.
module demux31_reg (
  input  logic          clk,
  input  logic          rst,
  demux31_reg_if.slave  bus
);
  localparam int unsigned DW    = 32;
  localparam int unsigned NCH   = 3;
  localparam int unsigned CNT_W = 8;

  logic [NCH-1:0] vld_q, vld_d;
  logic [DW-1:0]  dat_q [NCH];
  logic [DW-1:0]  dat_d [NCH];
  logic [NCH-1:0] rdy;
  logic           in_ready_c;
  logic           xfer_c;

  assign rdy = {bus.c_ready, bus.b_ready, bus.a_ready};

  // Accept when the selected channel is empty or draining this cycle; drops always accepted
  always_comb begin
    in_ready_c = 1'b1;
    case (bus.in_sel)
      2'b00:   in_ready_c = !vld_q[0] | rdy[0];
      2'b01:   in_ready_c = !vld_q[1] | rdy[1];
      2'b10:   in_ready_c = !vld_q[2] | rdy[2];
      default: in_ready_c = 1'b1;
    endcase
  end

  assign xfer_c = bus.in_valid & in_ready_c;

  // Channel next state: pop clears valid, a load on the same edge wins (no bubble)
  always_comb begin
    vld_d = vld_q;
    dat_d = dat_q;
    for (int i = 0; i < NCH; i++) begin
      if (vld_q[i] && rdy[i]) begin
        vld_d[i] = 1'b0;
      end
      if (xfer_c && (bus.in_sel == 2'(i))) begin
        vld_d[i] = 1'b1;
        dat_d[i] = bus.in_data;
      end
    end
  end

  // Channel holding registers
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      for (int i = 0; i < NCH; i++) begin
        dat_q[i] <= '0;
      end
    end else begin
      vld_q <= vld_d;
      for (int i = 0; i < NCH; i++) begin
        dat_q[i] <= dat_d[i];
      end
    end
  end

`ifdef DEMUX31_DROP_CNT_EN
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  // Saturating drop counter next state
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (xfer_c && (bus.in_sel == 2'b11) && (drop_cnt_q != {CNT_W{1'b1}})) begin
      drop_cnt_d = drop_cnt_q + CNT_W'(1);
    end
  end

  // Drop counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign bus.drop_cnt = drop_cnt_q;
`else
  assign bus.drop_cnt = CNT_W'(0);
`endif

  assign bus.in_ready = in_ready_c;
  assign bus.a_data   = dat_q[0];
  assign bus.b_data   = dat_q[1];
  assign bus.c_data   = dat_q[2];
  assign bus.a_valid  = vld_q[0];
  assign bus.b_valid  = vld_q[1];
  assign bus.c_valid  = vld_q[2];
endmodule

// File: tb/tb_demux31_reg.sv
// Self-checking bench for demux31_reg: directed scenarios followed by random
// traffic, checked every cycle against a queue-based channel model.
module tb_demux31_reg;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  demux31_reg_if bus ();

  demux31_reg dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model state: per-channel queue of words the consumer is owed,
  // last word ever loaded per channel, and number of dropped words.
  logic [31:0] scb [3][$];
  logic [31:0] lastd [3];
  int          drops = 0;
  bit          armed = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare DUT against model mid-cycle, then advance model to the next edge
  initial begin
    logic [2:0]  vld, rdy;
    logic [31:0] dat [3];
    logic        exp_rdy;
    int          s;
    forever begin
      @(negedge clk);
      vld = {bus.c_valid, bus.b_valid, bus.a_valid};
      rdy = {bus.c_ready, bus.b_ready, bus.a_ready};
      dat[0] = bus.a_data;
      dat[1] = bus.b_data;
      dat[2] = bus.c_data;
      s = int'(bus.in_sel);
      exp_rdy = (s == 3) || (scb[s].size() == 0) || rdy[s];
      if (armed) begin
        chk("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
        for (int i = 0; i < 3; i++) begin
          chk($sformatf("valid[%0d]", i), 32'(vld[i]), 32'(scb[i].size() != 0));
          chk($sformatf("data[%0d]", i), dat[i], (scb[i].size() != 0) ? scb[i][0] : lastd[i]);
        end
`ifdef DEMUX31_DROP_CNT_EN
        chk("drop_cnt", 32'(bus.drop_cnt), 32'((drops > 255) ? 255 : drops));
`else
        chk("drop_cnt", 32'(bus.drop_cnt), 32'h0);
`endif
      end
      if (rst) begin
        for (int i = 0; i < 3; i++) begin
          scb[i].delete();
          lastd[i] = 32'h0;
        end
        drops = 0;
        armed = 1'b1;
      end else if (armed) begin
        for (int i = 0; i < 3; i++) begin
          if (scb[i].size() != 0 && rdy[i]) void'(scb[i].pop_front());
        end
        if (bus.in_valid && exp_rdy) begin
          if (s == 3) drops++;
          else begin
            scb[s].push_back(bus.in_data);
            lastd[s] = bus.in_data;
          end
        end
      end
    end
  end

  task automatic drive(input logic v, input logic [1:0] sel, input logic [31:0] d,
                       input logic ar, input logic br, input logic cr);
    @(posedge clk);
    #1;
    bus.in_valid = v;
    bus.in_sel   = sel;
    bus.in_data  = d;
    bus.a_ready  = ar;
    bus.b_ready  = br;
    bus.c_ready  = cr;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Stimulus
  initial begin
    bus.in_valid = 1'b0;
    bus.in_sel   = 2'b00;
    bus.in_data  = 32'h0;
    bus.a_ready  = 1'b0;
    bus.b_ready  = 1'b0;
    bus.c_ready  = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Idle after reset, every sel must be accepted
    for (int s = 0; s < 4; s++) drive(1'b0, 2'(s), 32'h0, 1'b0, 1'b0, 1'b0);

    // Load a
    drive(1'b1, 2'b00, 32'hAAAAAAAA, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 2'b00, 32'h0, 1'b0, 1'b0, 1'b0);

    // b stall, then pop + reload on one edge
    drive(1'b1, 2'b01, 32'h55555555, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 2'b01, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 2'b01, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 2'b01, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 2'b01, 32'h0, 1'b0, 1'b0, 1'b0);

    // c stalled, a accepts independently
    drive(1'b1, 2'b10, 32'h12345678, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 2'b00, 32'hCAFEF00D, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 2'b00, 32'h0, 1'b0, 1'b0, 1'b0);

    // Drain everything, then 300 drops (counter saturation)
    drive(1'b0, 2'b00, 32'h0, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 300; i++) drive(1'b1, 2'b11, $urandom, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 2'b11, 32'h0, 1'b0, 1'b0, 1'b0);

    // Fill a/b/c, reset mid-stream
    drive(1'b1, 2'b00, 32'h11111111, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 2'b01, 32'h22222222, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 2'b10, 32'h33333333, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 2'b11, 32'h44444444, 1'b0, 1'b0, 1'b0);
    do_reset();
    for (int s = 0; s < 4; s++) drive(1'b0, 2'(s), 32'h0, 1'b0, 1'b0, 1'b0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 2'($urandom), $urandom,
            1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 3) != 0));
      if (i == 1500) do_reset();
    end

    drive(1'b0, 2'b00, 32'h0, 1'b1, 1'b1, 1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
